// File: rtl/video_pkg.sv
// Raster constants shared by the frame-buffer scan-out blocks.
package video_pkg;

  localparam int H_ACTIVE       = 32'd256;
  localparam int H_TOTAL        = 32'd320;
  localparam int HS_START       = 32'd272;
  localparam int HS_END         = 32'd304;
  localparam int V_ACTIVE       = 32'd224;
  localparam int V_TOTAL        = 32'd262;
  localparam int VS_START       = 32'd234;
  localparam int VS_END         = 32'd237;
  localparam int MID_LINE       = 32'd96;
  localparam logic [15:0] VRAM_BASE = 16'h2400;
  localparam int BYTES_PER_LINE = H_ACTIVE / 32'd8;

endpackage

// File: rtl/video_timing.sv
// Raster counters, display-enable, sync windows and the mid/end-of-screen
// interrupt pulses that pace CPU frame-buffer writes.
module video_timing #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_TOTAL  = video_pkg::H_TOTAL,
  parameter int HS_START = video_pkg::HS_START,
  parameter int HS_END   = video_pkg::HS_END,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_TOTAL  = video_pkg::V_TOTAL,
  parameter int VS_START = video_pkg::VS_START,
  parameter int VS_END   = video_pkg::VS_END,
  parameter int MID_LINE = video_pkg::MID_LINE,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          in_active,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          irq_mid,
  output logic          irq_end
);
  import video_pkg::*;

  logic [HW-1:0] h_r, h_next_s;
  logic [VW-1:0] v_r, v_next_s;
  logic h_last_s, v_last_s, in_active_s, hs_win_s, vs_win_s;
  logic active_r, hsync_r, vsync_r, irq_mid_r, irq_end_r;

  // Next raster position and the windows decoded from the current one.
  always_comb begin
    h_last_s    = (h_r == HW'(H_TOTAL - 32'sd1));
    v_last_s    = (v_r == VW'(V_TOTAL - 32'sd1));
    in_active_s = (h_r < HW'(H_ACTIVE)) && (v_r < VW'(V_ACTIVE));
    hs_win_s    = (h_r >= HW'(HS_START)) && (h_r < HW'(HS_END));
    vs_win_s    = (v_r >= VW'(VS_START)) && (v_r < VW'(VS_END));
    if (h_last_s) begin
      h_next_s = '0;
      if (v_last_s) begin
        v_next_s = '0;
      end else begin
        v_next_s = v_r + VW'(1'b1);
      end
    end else begin
      h_next_s = h_r + HW'(1'b1);
      v_next_s = v_r;
    end
  end

  // Counters and video flags advance on pix_ce; irq pulses are one clk wide
  // because they are cleared on every edge that does not set them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r       <= '0;
      v_r       <= '0;
      active_r  <= 1'b0;
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      irq_mid_r <= 1'b0;
      irq_end_r <= 1'b0;
    end else if (pix_ce) begin
      h_r       <= h_next_s;
      v_r       <= v_next_s;
      active_r  <= in_active_s;
      hsync_r   <= hs_win_s;
      vsync_r   <= vs_win_s;
      irq_mid_r <= h_last_s && (v_next_s == VW'(MID_LINE));
      irq_end_r <= h_last_s && (v_next_s == VW'(V_ACTIVE));
    end else begin
      irq_mid_r <= 1'b0;
      irq_end_r <= 1'b0;
    end
  end

  assign h_count   = h_r;
  assign v_count   = v_r;
  assign in_active = in_active_s;
  assign active    = active_r;
  assign hsync     = hsync_r;
  assign vsync     = vsync_r;
  assign irq_mid   = irq_mid_r;
  assign irq_end   = irq_end_r;

endmodule

// File: rtl/vram_scanner.sv
// Frame-buffer scan-out: drives the RAM read-port address from the raster
// position and serializes each fetched byte LSB first into 1-bpp pixels.
module vram_scanner #(
  parameter int ADDR_WIDTH = 32'd16,
  parameter logic [ADDR_WIDTH-1:0] VRAM_BASE = ADDR_WIDTH'(video_pkg::VRAM_BASE),
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_TOTAL  = video_pkg::H_TOTAL,
  parameter int HS_START = video_pkg::HS_START,
  parameter int HS_END   = video_pkg::HS_END,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_TOTAL  = video_pkg::V_TOTAL,
  parameter int VS_START = video_pkg::VS_START,
  parameter int VS_END   = video_pkg::VS_END,
  parameter int MID_LINE = video_pkg::MID_LINE,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_ce,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data,
  output logic                  pixel,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  irq_mid,
  output logic                  irq_end,
  output logic [HW-1:0]         h_count,
  output logic [VW-1:0]         v_count
);
  import video_pkg::*;

  localparam int LINE_BYTES = H_ACTIVE / 32'sd8;

  logic                  in_active_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  pixel_r;
  logic [6:0]            shift_r;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .HS_START (HS_START),
    .HS_END   (HS_END),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .VS_START (VS_START),
    .VS_END   (VS_END),
    .MID_LINE (MID_LINE)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_ce    (pix_ce),
    .h_count   (h_count),
    .v_count   (v_count),
    .in_active (in_active_s),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .irq_mid   (irq_mid),
    .irq_end   (irq_end)
  );

  // Byte address of the current 8-pixel group; parked on the base in blanking.
  always_comb begin
    if (in_active_s) begin
      addr_s = VRAM_BASE
             + ADDR_WIDTH'(v_count) * ADDR_WIDTH'(LINE_BYTES)
             + ADDR_WIDTH'(h_count[HW-1:3]);
    end else begin
      addr_s = VRAM_BASE;
    end
  end

  assign addr = addr_s;

  // Load a fresh byte on each 8-pixel boundary, otherwise shift out the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_r <= 1'b0;
      shift_r <= '0;
    end else if (pix_ce) begin
      if (in_active_s) begin
        if (h_count[2:0] == 3'd0) begin
          pixel_r <= data[0];
          shift_r <= data[7:1];
        end else begin
          pixel_r <= shift_r[0];
          shift_r <= {1'b0, shift_r[6:1]};
        end
      end else begin
        pixel_r <= 1'b0;
      end
    end
  end

  assign pixel = pixel_r;

endmodule

// File: tb/tb_vram_scanner.sv
// Directed bench for vram_scanner: reset, fetch/serialize, address boundaries,
// 1-in-4 pixel enable, interrupt timing and a full-frame sync/active census.
module tb_vram_scanner;

  localparam int HT    = 320;
  localparam int FRAME = 320 * 262;

  logic        clk, rst, pix_ce;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        pixel, active, hsync, vsync, irq_mid, irq_end;
  logic [8:0]  h_count, v_count;

  logic [7:0]  mem [0:65535];
  assign data = mem[addr];

  vram_scanner dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .addr(addr), .data(data),
    .pixel(pixel), .active(active), .hsync(hsync), .vsync(vsync),
    .irq_mid(irq_mid), .irq_end(irq_end), .h_count(h_count), .v_count(v_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks, fails;
  int   nsteps, mid_cnt, end_cnt, both_cnt, mid_at, end_at, hs_cnt, vs_cnt, act_cnt;
  bit   slow;
  logic pix_exp;
  logic [7:0] pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    nsteps = 0; mid_cnt = 0; end_cnt = 0; both_cnt = 0; mid_at = -1; end_at = -1;
    hs_cnt = 0; vs_cnt = 0; act_cnt = 0;
  endtask

  // One pix_ce step; in slow mode three disabled clocks follow and must hold.
  task automatic step();
    int pos;
    pix_ce = 1'b1;
    @(posedge clk); @(negedge clk);
    nsteps++;
    if (irq_mid) begin mid_cnt++; mid_at = nsteps; end
    if (irq_end) begin end_cnt++; end_at = nsteps; end
    if (irq_mid && irq_end) both_cnt++;
    if (hsync)  hs_cnt++;
    if (vsync)  vs_cnt++;
    if (active) act_cnt++;
    if (slow) begin
      pos = nsteps % FRAME;
      pix_ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); @(negedge clk);
        chk("hold_h", 32'(h_count), 32'(pos % HT));
        chk("hold_v", 32'(v_count), 32'(pos / HT));
        chk("hold_pixel", 32'(pixel), 32'(pix_exp));
        chk("hold_irq", 32'({irq_mid, irq_end}), 32'd0);
      end
      pix_ce = 1'b1;
    end
  endtask

  task automatic adv_to(input int th, input int tv);
    int n;
    n = ((tv * HT + th) - (nsteps % FRAME) + FRAME) % FRAME;
    repeat (n) step();
    chk("pos_h", 32'(h_count), 32'(th));
    chk("pos_v", 32'(v_count), 32'(tv));
  endtask

  initial begin
    checks = 0; fails = 0; slow = 1'b0; pix_exp = 1'b0;
    clear_stats();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2400] = 8'hA5;
    mem[16'h3FFF] = 8'h80;
    pat = 8'hA5;
    rst = 1'b1; pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("rst_h", 32'(h_count), 32'd0);
    chk("rst_v", 32'(v_count), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_sync", 32'({hsync, vsync}), 32'd0);
    chk("rst_irq", 32'({irq_mid, irq_end}), 32'd0);
    chk("rst_addr", 32'(addr), 32'h2400);

    rst = 1'b0;
    clear_stats();
    chk("addr_00", 32'(addr), 32'h2400);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("pixel_fast", 32'(pixel), 32'(pat[k]));
      if (k == 0) chk("active_first", 32'(active), 32'd1);
    end

    adv_to(8, 1);
    chk("addr_line1_h8", 32'(addr), 32'h2421);

    // Asynchronous reset in the middle of a line.
    adv_to(150, 40);
    #2 rst = 1'b1;
    #1;
    chk("mrst_hv", 32'({h_count, v_count}), 32'd0);
    chk("mrst_pixel", 32'(pixel), 32'd0);
    chk("mrst_active", 32'(active), 32'd0);
    chk("mrst_sync_irq", 32'({hsync, vsync, irq_mid, irq_end}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();

    // 1-in-4 enable must reproduce the same pixel sequence.
    slow = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pix_exp = pat[k];
      step();
      chk("pixel_slow", 32'(pixel), 32'(pat[k]));
    end
    slow = 1'b0;
    pix_exp = 1'b0;

    adv_to(316, 95);
    slow = 1'b1;
    adv_to(4, 96);
    slow = 1'b0;
    chk("irq_mid_count", 32'(mid_cnt), 32'd1);
    chk("irq_mid_at", 32'(mid_at), 32'(96 * 320));

    adv_to(255, 223);
    chk("addr_last", 32'(addr), 32'h3FFF);
    step();
    chk("addr_h256", 32'(addr), 32'h2400);
    chk("active_h255", 32'(active), 32'd1);
    chk("pixel_last", 32'(pixel), 32'd1);
    step();
    chk("active_h256", 32'(active), 32'd0);
    chk("pixel_blank", 32'(pixel), 32'd0);

    adv_to(319, 261);
    step();
    chk("wrap_hv", 32'({h_count, v_count}), 32'd0);
    chk("wrap_addr", 32'(addr), 32'h2400);
    chk("wrap_irq", 32'({irq_mid, irq_end}), 32'd0);
    chk("frame_steps", 32'(nsteps), 32'(FRAME));
    chk("irq_mid_frame", 32'(mid_cnt), 32'd1);
    chk("irq_end_frame", 32'(end_cnt), 32'd1);
    chk("irq_end_at", 32'(end_at), 32'(224 * 320));
    chk("irq_both", 32'(both_cnt), 32'd0);
    chk("hsync_total", 32'(hs_cnt), 32'(32 * 262));
    chk("vsync_total", 32'(vs_cnt), 32'(3 * 320));
    chk("active_total", 32'(act_cnt), 32'(256 * 224));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/vram_scanner.md
Name: vram_scanner

Overview:
Video scan-out sequencer for the dual-port frame-buffer RAM. It generates the raster timing and drives the RAM's asynchronous read-only port address. It serializes each fetched byte into 1-bpp pixels, LSB first. It also raises the mid-screen and end-of-screen interrupt requests that the CPU uses to pace its frame-buffer writes.

Parameters:
ADDR_WIDTH, 16, width of the RAM read-port address.
VRAM_BASE, 16'h2400, address of pixel byte for (x=0, y=0).
H_ACTIVE, 256, visible pixels per line; must be a multiple of 8.
H_TOTAL, 320, pixel periods per line including blanking.
HS_START, 272, first h count with hsync asserted.
HS_END, 304, first h count with hsync deasserted.
V_ACTIVE, 224, visible lines per frame.
V_TOTAL, 262, lines per frame.
VS_START, 234, first line with vsync asserted.
VS_END, 237, first line with vsync deasserted.
MID_LINE, 96, line on whose start irq_mid fires.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
pix_ce  input  1  pixel clock enable; all raster state advances only on clk edges with pix_ce=1
addr  output  ADDR_WIDTH  read address to RAM port 2 (combinational from counters)
data  input  8  RAM port 2 read data (combinational from addr, same cycle)
pixel  output  1  registered pixel value
active  output  1  registered display-enable, aligned with pixel
hsync  output  1  registered, active-high, aligned with pixel
vsync  output  1  registered, active-high, aligned with pixel
irq_mid  output  1  one-clk pulse at the start of line MID_LINE
irq_end  output  1  one-clk pulse at the start of line V_ACTIVE
h_count  output  clog2(H_TOTAL)  current horizontal counter (debug/bench)
v_count  output  clog2(V_TOTAL)  current vertical counter

Behaviour:
- Reset (asynchronous): h_count=0, v_count=0, shift register=0. pixel, active, hsync, vsync, irq_mid and irq_end all 0. Release is synchronous to clk.
- Counters, on pix_ce:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 at V_TOTAL-1 when h wraps.
  - With pix_ce=0, all registers hold and irq outputs are 0.
- in_active = (h < H_ACTIVE) && (v < V_ACTIVE).
- addr:
  - When in_active: VRAM_BASE + v*(H_ACTIVE/8) + h[msb:3], computed at ADDR_WIDTH and truncated on overflow.
  - Otherwise: VRAM_BASE.
  - Example: v=1, h=8 gives 16'h2421.
- Fetch/serialize, on pix_ce:
  - in_active and h[2:0]==0: pixel<=data[0], shift<=data[7:1].
  - in_active, otherwise: pixel<=shift[0], shift<=shift>>1.
  - Not in_active: pixel<=0.
- Output alignment: active, hsync and vsync are registered from the current counters on the same pix_ce, so all four video outputs show one pix_ce step of latency relative to h/v.
- Sync windows:
  - hsync = (HS_START <= h < HS_END).
  - vsync = (VS_START <= v < VS_END).
- Interrupts:
  - irq_mid=1 for exactly one clk on the pix_ce edge where the counters become (h=0, v=MID_LINE).
  - irq_end=1 likewise for (h=0, v=V_ACTIVE).
  - Never both in the same cycle.
  - Pulses are not re-armed until the next frame.
- Simultaneous events: the h wrap and v wrap on the same edge produce (0,0) with no interrupt pulse.
- Reset mid-line: everything returns immediately to the reset values, and the first frame after release is full length.
- The data read is never stalled or arbitrated; port 2 is dedicated to this block.

Decomposition:
- Package video_pkg holds the raster constants:
  - H_ACTIVE, H_TOTAL, HS_START, HS_END.
  - V_ACTIVE, V_TOTAL, VS_START, VS_END.
  - MID_LINE, VRAM_BASE, BYTES_PER_LINE = H_ACTIVE/8.
- One sub-module, video_timing, holds the h/v counters, in_active, the sync windows and interrupt pulse generation.
- vram_scanner keeps the address generation and the shift register.

Test Plan:
- Reset asserted mid-frame with counters at (150, 40): all outputs 0 and counters 0 on the same cycle; after release, irq_mid arrives after exactly 96*320 pix_ce.
- RAM preset with byte 0 = 8'hA5 and pix_ce=1 every clk: addr=16'h2400 at h=0; pixel over the following 8 steps = 1,0,1,0,0,1,0,1.
- Line 1, h=8: addr=16'h2421. Last active pixel (h=255, v=223): addr=16'h3FFF. At h=256, active drops and addr=VRAM_BASE.
- One full frame with pix_ce=1: exactly one irq_mid at (0,96) and one irq_end at (0,224); total 83840 pix_ce per frame; hsync high 32 pixels/line; vsync high 3 lines.
- pix_ce toggling 1-in-4: counters and pixel hold on non-enabled cycles; irq pulses last one clk, not four; pixel sequence is identical to the pix_ce=1 case.
- Wrap at (319, 261): the next step gives (0,0), addr=16'h2400, no irq pulse.
